sl_rx_ctrl: RTL

Host-side controller for the serial-line (SL) receiver: sequences configuration writes into the receiver, captures completed words and error events, buffers good words in a small FIFO, and exposes a one-hot-addressed register port with an interrupt line. Sits between the system register bus and one SL receiver instance, on the same 16 MHz clock.

---
 rtl/sl_pkg.sv | 49 ++++
 rtl/sl_rx_fifo.sv | 52 +++++
 rtl/sl_rx_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sl_pkg.sv
// Shared constants for the serial-line receiver controller: bus addresses,
// receiver config/status bit positions, controller status layout, FSM states.
package sl_pkg;

  localparam logic [3:0] ADDR_CONFIG  = 4'b0001;
  localparam logic [3:0] ADDR_DATA_WR = 4'b0010;
  localparam logic [3:0] ADDR_DATA_R  = 4'b0100;
  localparam logic [3:0] ADDR_STATUS  = 4'b1000;

  // Receiver configuration word fields
  localparam int CFG_PCE  = 0;
  localparam int CFG_BQL  = 1;
  localparam int CFG_BQH  = 6;
  localparam int CFG_MODE = 7;
  localparam int CFG_IRQM = 8;

  localparam logic [15:0] CFG_RESET = 16'h0010;

  // Receiver status word fields
  localparam int RS_WLC = 0;
  localparam int RS_WRP = 1;
  localparam int RS_WRF = 3;
  localparam int RS_PEF = 4;
  localparam int RS_LEF = 5;

  // Controller STATUS register fields
  localparam int ST_EMPTY = 4;
  localparam int ST_FULL  = 5;
  localparam int ST_OVF   = 6;
  localparam int ST_PEF   = 7;
  localparam int ST_WLC   = 8;
  localparam int ST_LEF   = 9;
  localparam int ST_CFE   = 10;
  localparam int ST_PEND  = 11;
  localparam int ST_WRP   = 12;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_WAIT = 1'b1
  } cfg_state_e;

  // Bit quantity must be even and within 8..32.
  function automatic logic cfg_bq_ok(input logic [15:0] cfg);
    logic [5:0] bq;
    bq = cfg[CFG_BQH:CFG_BQL];
    return !bq[0] && (bq >= 6'd8) && (bq <= 6'd32);
  endfunction

endpackage

// File: rtl/sl_rx_fifo.sv
// Synchronous FIFO with registered count; push and pop in the same cycle
// both succeed even when full.
module sl_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sl_rx_ctrl.sv
// Host-side controller for one SL receiver: config write sequencing, event
// capture into a good-word FIFO, sticky error flags and a one-hot register port.
module sl_rx_ctrl
  import sl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CFG_RETRY  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        irq,
  output logic [15:0] rx_config_w,
  output logic        rx_wr_enable,
  input  logic [15:0] rx_config_r,
  input  logic [15:0] rx_status_w,
  input  logic [31:0] rx_data_w,
  input  logic        rx_data_status_changed
);

  localparam int RW  = $clog2(CFG_RETRY + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  cfg_state_e      state;
  logic [15:0]     pend_cfg;
  logic [RW-1:0]   retry_cnt;
  logic            cfg_wr;
  logic            cfg_load;
  logic            cfg_bad;
  logic            cfg_timeout;

  logic            ovf, pef, wlc, lef, cfe;
  logic [7:0]      err_cnt;

  logic            evt_good, set_ovf, set_pef, set_wlc, set_lef, err_evt;
  logic            rd_status, rd_data, pop_eff;

  logic [31:0]     fifo_head;
  logic            fifo_full, fifo_empty;
  logic [FCW-1:0]  fifo_count;
  logic [4:0]      count_ext;
  logic [3:0]      count_sat;
  logic [31:0]     status_word;
  logic [31:0]     read_mux;
  logic            unused_bits;

  // A write that coincides with a read is dropped.
  assign cfg_wr      = wr_en && !rd_en && (addr == ADDR_CONFIG);
  assign cfg_load    = cfg_wr && cfg_bq_ok(wdata[15:0]);
  assign cfg_bad     = cfg_wr && !cfg_bq_ok(wdata[15:0]);
  assign cfg_timeout = !cfg_load && (state == CFG_WAIT) && (rx_config_r != pend_cfg)
                       && (retry_cnt == RW'(CFG_RETRY - 1));
  assign rx_config_w = pend_cfg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= CFG_IDLE;
      pend_cfg     <= CFG_RESET;
      retry_cnt    <= '0;
      rx_wr_enable <= 1'b0;
    end else if (cfg_load) begin
      state        <= CFG_WAIT;
      pend_cfg     <= wdata[15:0];
      retry_cnt    <= '0;
      rx_wr_enable <= 1'b1;
    end else if (state == CFG_WAIT) begin
      if ((rx_config_r == pend_cfg) || cfg_timeout) begin
        state        <= CFG_IDLE;
        rx_wr_enable <= 1'b0;
      end else begin
        retry_cnt <= retry_cnt + RW'(1);
      end
    end
  end

  // Event decode: errors are only meaningful on a finished word, except LEF.
  assign evt_good  = rx_data_status_changed && rx_status_w[RS_WRF]
                     && !rx_status_w[RS_PEF] && !rx_status_w[RS_WLC];
  assign set_pef   = rx_data_status_changed && rx_status_w[RS_WRF] && rx_status_w[RS_PEF];
  assign set_wlc   = rx_data_status_changed && rx_status_w[RS_WRF] && rx_status_w[RS_WLC];
  assign set_lef   = rx_data_status_changed && rx_status_w[RS_LEF];
  assign err_evt   = set_pef || set_wlc || set_lef;

  assign rd_status = rd_en && (addr == ADDR_STATUS);
  assign rd_data   = rd_en && (addr == ADDR_DATA_R);
  assign pop_eff   = rd_data && !fifo_empty;
  assign set_ovf   = evt_good && fifo_full && !pop_eff;

  sl_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (evt_good),
    .pop   (rd_data),
    .wdata (rx_data_w),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky flags: a set arriving with the clearing read survives it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {ovf, pef, wlc, lef, cfe} <= '0;
      err_cnt <= '0;
    end else begin
      ovf <= (ovf && !rd_status) || set_ovf;
      pef <= (pef && !rd_status) || set_pef;
      wlc <= (wlc && !rd_status) || set_wlc;
      lef <= (lef && !rd_status) || set_lef;
      cfe <= (cfe && !rd_status) || cfg_bad || cfg_timeout;
      // One increment per erroneous event, regardless of how many flags it carries.
      if (err_evt)        err_cnt <= rd_status ? 8'd1 : ((err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1);
      else if (rd_status) err_cnt <= 8'd0;
    end
  end

  assign count_ext   = 5'(fifo_count);
  assign count_sat   = (count_ext > 5'd15) ? 4'hF : count_ext[3:0];
  assign status_word = {8'h00, err_cnt, 3'b000, rx_status_w[RS_WRP], (state == CFG_WAIT),
                        cfe, lef, wlc, pef, ovf, fifo_full, fifo_empty, count_sat};

  always_comb begin
    read_mux = 32'h0;
    case (addr)
      ADDR_CONFIG: read_mux = {16'h0000, rx_config_r};
      ADDR_DATA_R: read_mux = fifo_empty ? 32'h0 : fifo_head;
      ADDR_STATUS: read_mux = status_word;
      default:     read_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata  <= 32'h0;
      rvalid <= 1'b0;
      irq    <= 1'b0;
    end else begin
      rdata  <= rd_en ? read_mux : 32'h0;
      rvalid <= rd_en;
      irq    <= !fifo_empty || (rx_config_r[CFG_IRQM] && (ovf || pef || wlc || lef || cfe));
    end
  end

  assign unused_bits = ^{wdata[31:16], rx_status_w[15:6], rx_status_w[2]};

endmodule
